piso_serializer: RTL



---
 rtl/piso_serializer_if.sv | 33 +++
 rtl/piso_serializer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/piso_serializer_if.sv
// Word-side handshake and bit-serial output bundle of the PISO serializer.
// The producer uses the master view, the serializer the slave view.
interface piso_serializer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] datain;
    logic             validIn;
    logic             readyIn;
    logic             dataout;
    logic             validOut;
    logic             firstOut;
    logic             lastOut;

    modport master (
        output datain,
        output validIn,
        input  readyIn,
        input  dataout,
        input  validOut,
        input  firstOut,
        input  lastOut
    );

    modport slave (
        input  datain,
        input  validIn,
        output readyIn,
        output dataout,
        output validOut,
        output firstOut,
        output lastOut
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: WIDTH-bit words in over valid/ready,
// one bit per clock out, with a one-word holding buffer for zero-gap streaming.
module piso_serializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    piso_serializer_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_hfull;
    logic             w_hfull_nxt;
    logic             w_ready;
    logic             w_accept;
    logic             w_valid;
    logic             w_bit;

    // Advance the shift register by one bit in the configured direction.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] result;
        if (MSB_FIRST) begin
            result = {word[WIDTH-2:0], 1'b0};
        end else begin
            result = {1'b0, word[WIDTH-1:1]};
        end
        return result;
    endfunction

    // readyIn follows only the holding flag, so a full buffer can never collide with a reload.
    assign w_ready  = ~r_hfull & ~rst;
    assign w_accept = bus.validIn & w_ready;

    assign w_valid = (r_state == ST_SHIFT);
    assign w_bit   = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

    assign bus.readyIn  = w_ready;
    assign bus.validOut = w_valid;
    assign bus.dataout  = w_valid & w_bit;
    assign bus.firstOut = w_valid & (r_cnt == CNT_ZERO);
    assign bus.lastOut  = w_valid & (r_cnt == CNT_LAST);

    // Next-state decode: load, shift, reload from HOLD, or bypass on the last bit.
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_hold_nxt  = r_hold;
        w_cnt_nxt   = r_cnt;
        w_hfull_nxt = r_hfull;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sreg_nxt  = bus.datain;
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
            end
            ST_SHIFT: begin
                if (r_cnt != CNT_LAST) begin
                    w_sreg_nxt = shift_word(r_sreg);
                    w_cnt_nxt  = r_cnt + CNT_ONE;
                    if (w_accept) begin
                        w_hold_nxt  = bus.datain;
                        w_hfull_nxt = 1'b1;
                    end else begin
                        w_hfull_nxt = r_hfull;
                    end
                end else if (r_hfull) begin
                    w_sreg_nxt  = r_hold;
                    w_hfull_nxt = 1'b0;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (w_accept) begin
                    // Bypass: the word goes straight into SREG, HOLD stays empty.
                    w_sreg_nxt = bus.datain;
                    w_cnt_nxt  = CNT_ZERO;
                end else begin
                    w_sreg_nxt  = '0;
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sreg_nxt  = '0;
                w_cnt_nxt   = CNT_ZERO;
                w_hfull_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partially sent word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_hold  <= '0;
            r_cnt   <= CNT_ZERO;
            r_hfull <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_hold  <= w_hold_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hfull <= w_hfull_nxt;
        end
    end
endmodule
